lsb_serial_comparator: RTL and testbench

//  Multi-cycle magnitude comparator for the 2nd-division datapath. Scans two unsigned

---
 rtl/lsb_serial_comparator_pkg.sv | 26 ++
 rtl/lsb_comp_cell.sv | 16 +
 rtl/lsb_serial_comparator.sv | 159 +++++++++++++++
 tb/tb_lsb_serial_comparator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_serial_comparator_pkg.sv
// Shared definitions for the LSB-first serial magnitude comparator: FSM states,
// relation codes and the single-bit fold used by every comparator cell.
package lsb_serial_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [1:0] REL_GT = 2'b10;
    localparam logic [1:0] REL_LT = 2'b01;

    // A differing bit at a higher position overrides whatever the lower bits decided.
    function automatic logic [1:0] fold_bit(input logic a, input logic b, input logic [1:0] c);
        logic [1:0] r;
        if (a != b) begin
            r = {a & ~b, ~a & b};
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsb_comp_cell.sv
// One bit of the LSB-first compare chain: folds operand bits a/b into relation c.
module lsb_comp_cell
    import lsb_serial_comparator_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] c,
    output logic [1:0] c_next
);

    // Pure combinational fold of one bit pair.
    always_comb begin
        c_next = fold_bit(a, b, c);
    end

endmodule

// File: rtl/lsb_serial_comparator.sv
// Multi-cycle unsigned magnitude comparator scanning operands LSB-first,
// BITS_PER_CYCLE bits per clock, with valid/ready handshakes on both sides.
module lsb_serial_comparator
    import lsb_serial_comparator_pkg::*;
#(
    parameter int WIDTH          = 24,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             GT,
    output logic             LT,
    output logic             EQ,
    output logic             BUSY
);

    localparam int NGROUPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NGROUPS - 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("lsb_serial_comparator: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               accept_s;
    logic [1:0]         fold_s [BITS_PER_CYCLE+1];

    assign fold_s[0] = c_q;

    // Cell chain over the current group, lowest bit first so higher bits win.
    generate
        for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_cell
            lsb_comp_cell u_cell (
                .a      (a_q[g]),
                .b      (b_q[g]),
                .c      (fold_s[g]),
                .c_next (fold_s[g+1])
            );
        end
    endgenerate

    assign accept_s = IN_VALID & IN_READY;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_d = IN_VALID ? ST_RUN : ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; IN_READY deliberately follows OUT_READY combinationally.
    always_comb begin
        IN_READY  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & OUT_READY);
        OUT_VALID = (state_q == ST_DONE);
        BUSY      = (state_q == ST_RUN);
        GT        = gt_q;
        LT        = lt_q;
        EQ        = eq_q;
    end

    // Datapath next values: capture, shift-and-fold, and result latch on the last group.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        gt_d  = gt_q;
        lt_d  = lt_q;
        eq_d  = eq_q;
        if (accept_s) begin
            a_d   = A;
            b_d   = B;
            c_d   = REL_EQ;
            cnt_d = CNT_LOAD;
        end else if (state_q == ST_RUN) begin
            a_d = a_q >> BITS_PER_CYCLE;
            b_d = b_q >> BITS_PER_CYCLE;
            c_d = fold_s[BITS_PER_CYCLE];
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                gt_d = fold_s[BITS_PER_CYCLE][1];
                lt_d = fold_s[BITS_PER_CYCLE][0];
                eq_d = ~|fold_s[BITS_PER_CYCLE];
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= REL_EQ;
            cnt_q <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            gt_q  <= gt_d;
            lt_q  <= lt_d;
            eq_q  <= eq_d;
        end
    end

endmodule

// File: tb/tb_lsb_serial_comparator.sv
// Self-checking bench: two comparator instances (1 and 4 bits per cycle) checked
// against plain unsigned relational operators on random and directed operands.
module tb_lsb_serial_comparator;

    localparam int N1 = 24;
    localparam int N4 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst;
    logic        iv1, ir1, ov1, or1, gt1, lt1, eq1, busy1;
    logic [23:0] a1, b1;
    logic        iv4, ir4, ov4, or4, gt4, lt4, eq4, busy4;
    logic [23:0] a4, b4;

    lsb_serial_comparator #(.WIDTH(24), .BITS_PER_CYCLE(1)) dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(iv1), .IN_READY(ir1), .A(a1), .B(b1),
        .OUT_VALID(ov1), .OUT_READY(or1), .GT(gt1), .LT(lt1), .EQ(eq1), .BUSY(busy1)
    );

    lsb_serial_comparator #(.WIDTH(24), .BITS_PER_CYCLE(4)) dut4 (
        .CLK(clk), .RST(rst), .IN_VALID(iv4), .IN_READY(ir4), .A(a4), .B(b4),
        .OUT_VALID(ov4), .OUT_READY(or4), .GT(gt4), .LT(lt4), .EQ(eq4), .BUSY(busy4)
    );

    function automatic logic [2:0] ref_rel(input logic [23:0] x, input logic [23:0] y);
        if (x > y) return 3'b100;
        else if (x < y) return 3'b010;
        else return 3'b001;
    endfunction

    function automatic logic [23:0] rand_b(input logic [23:0] x);
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return x;
        else if (k == 1) return x ^ (24'd1 << $urandom_range(0, 23));
        else return 24'($urandom);
    endfunction

    // Drive one pair into dut1 and wait for its result; lat counts edges after accept.
    task automatic run1(input logic [23:0] x, input logic [23:0] y, output int lat, output logic [2:0] res);
        int guard;
        @(negedge clk);
        iv1 = 1'b1; a1 = x; b1 = y;
        #1;
        guard = 0;
        while (!ir1 && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = ov1 ? {gt1, lt1, eq1} : 3'bxxx;
    endtask

    task automatic run4(input logic [23:0] x, input logic [23:0] y, output int lat, output logic [2:0] res);
        int guard;
        @(negedge clk);
        iv4 = 1'b1; a4 = x; b4 = y;
        #1;
        guard = 0;
        while (!ir4 && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = ov4 ? {gt4, lt4, eq4} : 3'bxxx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (ir1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready1 got=%b exp=1", ir1); end
        total++;
        if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid1 got=%b exp=0", ov1); end
        total++;
        if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        total++;
        if ({gt1, lt1, eq1} !== 3'b000) begin bad++; $display("FAIL reset_rel1 got=%b exp=000", {gt1, lt1, eq1}); end
        total++;
        if ({ir4, ov4, busy4} !== 3'b100) begin bad++; $display("FAIL reset_flags4 got=%b exp=100", {ir4, ov4, busy4}); end
        total++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [23:0] va [6];
        logic [23:0] vb [6];
        int          lat;
        logic [2:0]  res;
        va = '{24'h800000, 24'h5A5A5A, 24'h010001, 24'h000000, 24'hFFFFFF, 24'h000000};
        vb = '{24'h7FFFFF, 24'h5A5A5A, 24'h020000, 24'h000000, 24'h000000, 24'hFFFFFF};
        for (int i = 0; i < 6; i++) begin
            run1(va[i], vb[i], lat, res);
            if (lat !== N1) begin bad++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, N1); end
            total++;
            if (res !== ref_rel(va[i], vb[i])) begin
                bad++; $display("FAIL directed_rel[%0d] a=%h b=%h got=%b exp=%b", i, va[i], vb[i], res, ref_rel(va[i], vb[i]));
            end
            total++;
        end
    endtask

    task automatic test_hold_and_handoff();
        int         lat;
        logic [2:0] res;
        or1 = 1'b0;
        run1(24'h123456, 24'h123457, lat, res);
        if (res !== 3'b010) begin bad++; $display("FAIL hold_first_rel got=%b exp=010", res); end
        total++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if ({ov1, gt1, lt1, eq1} !== 4'b1010) begin
                bad++; $display("FAIL hold_stable[%0d] got=%b exp=1010", i, {ov1, gt1, lt1, eq1});
            end
            total++;
        end
        @(negedge clk);
        or1 = 1'b1; iv1 = 1'b1; a1 = 24'hFFFFFF; b1 = 24'hFFFFFE;
        #1;
        if (ir1 !== 1'b1) begin bad++; $display("FAIL handoff_in_ready got=%b exp=1", ir1); end
        total++;
        @(posedge clk); #1;
        iv1 = 1'b0;
        if ({busy1, ov1} !== 2'b10) begin bad++; $display("FAIL handoff_busy got=%b exp=10", {busy1, ov1}); end
        total++;
        lat = 0;
        while (!ov1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (lat !== N1) begin bad++; $display("FAIL handoff_latency got=%0d exp=%0d", lat, N1); end
        total++;
        if ({gt1, lt1, eq1} !== 3'b100) begin bad++; $display("FAIL handoff_rel got=%b exp=100", {gt1, lt1, eq1}); end
        total++;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        iv1 = 1'b1; a1 = 24'h000001; b1 = 24'h000000;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if ({ir1, ov1, busy1} !== 3'b100) begin bad++; $display("FAIL abort_flags got=%b exp=100", {ir1, ov1, busy1}); end
        total++;
        seen = 0;
        for (int i = 0; i < N1 + 6; i++) begin
            @(posedge clk); #1;
            if (ov1) seen++;
        end
        if (seen !== 0) begin bad++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
        total++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] qa[$];
        logic [23:0] qb[$];
        logic [23:0] ea, eb;
        int          cyc, last, got;
        logic        acc;
        cyc = 0; last = -1; got = 0;
        or1 = 1'b1;
        @(negedge clk);
        a1 = 24'($urandom); b1 = rand_b(a1); iv1 = 1'b1;
        while (got < 8 && cyc < 400) begin
            #1;
            acc = ir1;
            if (acc) begin qa.push_back(a1); qb.push_back(b1); end
            @(posedge clk); #1;
            cyc++;
            if (ov1) begin
                if (qa.size() == 0) begin
                    bad++; $display("FAIL b2b_spurious got=1 exp=0");
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front();
                    if ({gt1, lt1, eq1} !== ref_rel(ea, eb)) begin
                        bad++; $display("FAIL b2b_rel a=%h b=%h got=%b exp=%b", ea, eb, {gt1, lt1, eq1}, ref_rel(ea, eb));
                    end
                end
                total++;
                if (last >= 0) begin
                    if (cyc - last !== N1 + 1) begin bad++; $display("FAIL b2b_interval got=%0d exp=%0d", cyc - last, N1 + 1); end
                    total++;
                end
                last = cyc;
                got++;
            end
            @(negedge clk);
            if (acc) begin a1 = 24'($urandom); b1 = rand_b(a1); end
        end
        iv1 = 1'b0;
        if (got !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
        total++;
        repeat (N1 + 2) @(posedge clk);
    endtask

    task automatic test_random_bpc1();
        int          lat;
        logic [2:0]  res;
        logic [23:0] x, y;
        for (int i = 0; i < 300; i++) begin
            x = 24'($urandom); y = rand_b(x);
            run1(x, y, lat, res);
            if (lat !== N1) begin bad++; $display("FAIL rand1_latency a=%h b=%h got=%0d exp=%0d", x, y, lat, N1); end
            total++;
            if (res !== ref_rel(x, y)) begin bad++; $display("FAIL rand1_rel a=%h b=%h got=%b exp=%b", x, y, res, ref_rel(x, y)); end
            total++;
        end
    endtask

    task automatic test_bpc4();
        int          lat;
        logic [2:0]  res;
        logic [23:0] x, y;
        run4(24'h000010, 24'h00000F, lat, res);
        if (lat !== N4) begin bad++; $display("FAIL bpc4_latency got=%0d exp=%0d", lat, N4); end
        total++;
        if (res !== 3'b100) begin bad++; $display("FAIL bpc4_directed got=%b exp=100", res); end
        total++;
        for (int i = 0; i < 3000; i++) begin
            x = 24'($urandom); y = rand_b(x);
            run4(x, y, lat, res);
            if (lat !== N4) begin bad++; $display("FAIL rand4_latency a=%h b=%h got=%0d exp=%0d", x, y, lat, N4); end
            total++;
            if (res !== ref_rel(x, y)) begin bad++; $display("FAIL rand4_rel a=%h b=%h got=%b exp=%b", x, y, res, ref_rel(x, y)); end
            total++;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b1; a1 = 24'h0; b1 = 24'h0;
        iv4 = 1'b0; or4 = 1'b1; a4 = 24'h0; b4 = 24'h0;
        test_reset();
        test_directed();
        test_hold_and_handoff();
        test_reset_mid_run();
        test_back_to_back();
        test_random_bpc1();
        test_bpc4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
